// File: rtl/ifu_prefetch_queue.sv
// Decoupled instruction prefetcher: in-order fetch requests, DEPTH-entry PC-tagged queue, flush on redirect.
// A response is visible one cycle later; requests stop when entries plus stale in-flight responses reach DEPTH.
module ifu_prefetch_queue #(
    parameter int              XLEN     = 64,
    parameter int              ILEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = 64'h8000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            req_valid,
    input  logic            req_ready,
    output logic [XLEN-1:0] req_addr,
    input  logic            resp_valid,
    input  logic [ILEN-1:0] resp_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [ILEN-1:0] out_inst
);
    localparam int PW = $clog2(DEPTH);
    typedef logic [PW:0] ptr_t;

    localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);
    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(3);

    ptr_t            head;
    ptr_t            tail;
    ptr_t            fill;
    ptr_t            drop_cnt;
    logic [XLEN-1:0] fetch_pc;
    logic            fetch_en;

    logic [XLEN-1:0] pc_mem   [DEPTH];
    logic [ILEN-1:0] inst_mem [DEPTH];

    ptr_t            alloc_cnt;
    ptr_t            unfilled;
    ptr_t            credit_use;
    ptr_t            redir_sum;
    ptr_t            redir_drop;
    logic            full;
    logic            req_fire;
    logic            resp_drop;
    logic            resp_fill;
    logic            pop;
    logic [XLEN-1:0] redirect_target;

    assign alloc_cnt  = tail - head;
    assign unfilled   = tail - fill;
    assign full       = (head[PW] != tail[PW]) && (head[PW-1:0] == tail[PW-1:0]);
    // alloc + drop never exceeds DEPTH, so the pointer width holds the sum.
    assign credit_use = alloc_cnt + drop_cnt;

    // fetch_en holds requests off until the first edge after reset release.
    assign req_valid  = fetch_en && !full && (credit_use < ptr_t'(DEPTH)) && !redirect_valid;
    assign req_addr   = fetch_pc;
    assign req_fire   = req_valid && req_ready;

    assign resp_drop  = resp_valid && (drop_cnt != '0);
    assign resp_fill  = resp_valid && (drop_cnt == '0) && (fill != tail);

    assign out_valid  = (head != fill);
    assign pop        = out_valid && out_ready;
    assign out_pc     = out_valid ? pc_mem[head[PW-1:0]]   : '0;
    assign out_inst   = out_valid ? inst_mem[head[PW-1:0]] : '0;

    assign redirect_target = redirect_pc & ~ALIGN_MASK;

    // A response arriving in the redirect cycle retires one of the in-flight requests.
    always_comb begin
        redir_sum  = drop_cnt + unfilled;
        redir_drop = redir_sum;
        if (resp_valid && (redir_sum != '0)) begin
            redir_drop = redir_sum - ptr_t'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head     <= '0;
            tail     <= '0;
            fill     <= '0;
            drop_cnt <= '0;
            fetch_pc <= RESET_PC;
            fetch_en <= 1'b0;
        end else begin
            fetch_en <= 1'b1;
            if (redirect_valid) begin
                head     <= tail;
                fill     <= tail;
                drop_cnt <= redir_drop;
                fetch_pc <= redirect_target;
            end else begin
                if (req_fire) begin
                    tail     <= tail + ptr_t'(1);
                    fetch_pc <= fetch_pc + PC_STEP;
                end
                if (pop) begin
                    head <= head + ptr_t'(1);
                end
                if (resp_drop) begin
                    drop_cnt <= drop_cnt - ptr_t'(1);
                end
                if (resp_fill) begin
                    fill <= fill + ptr_t'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (req_fire) begin
            pc_mem[tail[PW-1:0]] <= fetch_pc;
        end
        if (resp_fill && !redirect_valid) begin
            inst_mem[fill[PW-1:0]] <= resp_data;
        end
    end
endmodule

// File: tb/tb_ifu_prefetch_queue.sv
// Scoreboard bench for ifu_prefetch_queue: randomized memory/IDU behaviour against a queue-level model.
module tb_ifu_prefetch_queue;
    localparam int          DEPTH    = 4;
    localparam logic [63:0] RESET_PC = 64'h8000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic        req_valid;
    logic        req_ready = 1'b0;
    logic [63:0] req_addr;
    logic        resp_valid = 1'b0;
    logic [31:0] resp_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_pc;
    logic [31:0] out_inst;

    ifu_prefetch_queue #(.XLEN(64), .ILEN(32), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .resp_valid(resp_valid), .resp_data(resp_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    // Expected queue contents (one per accepted request since the last flush) and memory in flight.
    logic [63:0] exp_pc[$];
    logic [31:0] exp_inst[$];
    bit          exp_filled[$];
    logic [63:0] mem_addr[$];
    int          mem_due[$];
    bit          mem_stale[$];

    logic [63:0] model_pc = RESET_PC;
    int          last_due = 0;
    int          req_cnt = 0;
    int          pop_cnt = 0;
    int          since_rst = 0;
    bit          prev_stall = 0;
    logic [63:0] prev_addr = '0;
    bit          arm_req = 0, arm_pop = 0, redir_seen = 0;
    logic [63:0] first_req_addr = '0, first_pop_pc = '0, last_req_addr = '0;

    int          rr_pct = 0, or_pct = 0, lat_min = 0, lat_max = 0, redir_pct = 0;
    bit          force_redir = 0, redir_on_ov = 0;
    logic [63:0] redir_target = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int stale_count();
        int n = 0;
        foreach (mem_stale[i]) if (mem_stale[i]) n++;
        return n;
    endfunction

    // Monitor: samples on the falling edge, compares against the model, then advances it.
    always @(negedge clk) begin
        if (!rst) begin
            since_rst  = 0;
            prev_stall = 0;
        end else begin
            bit exp_rv;
            exp_rv = (exp_pc.size() + stale_count() < DEPTH) && !redirect_valid;
            if (since_rst >= 1) chk("req_valid", req_valid, exp_rv);
            chk("out_valid", out_valid, (exp_pc.size() > 0) ? exp_filled[0] : 1'b0);
            if (prev_stall && !redirect_valid) begin
                chk("stall_valid", req_valid, 1);
                chk("stall_addr", req_addr, prev_addr);
            end
            prev_stall = req_valid && !req_ready;
            prev_addr  = req_addr;
            if (!out_valid) begin
                chk("idle_pc", out_pc, 0);
                chk("idle_inst", out_inst, 0);
            end
            if (resp_valid && mem_addr.size() > 0) begin
                if (!mem_stale[0]) begin
                    for (int i = 0; i < exp_filled.size(); i++) begin
                        if (!exp_filled[i]) begin
                            exp_filled[i] = 1;
                            break;
                        end
                    end
                end
                void'(mem_addr.pop_front());
                void'(mem_due.pop_front());
                void'(mem_stale.pop_front());
            end
            if (redirect_valid) begin
                exp_pc.delete();
                exp_inst.delete();
                exp_filled.delete();
                foreach (mem_stale[i]) mem_stale[i] = 1'b1;
                model_pc   = redirect_pc & ~64'h3;
                arm_req    = 1;
                arm_pop    = 1;
                redir_seen = 1;
            end else begin
                if (out_valid && out_ready) begin
                    if (exp_pc.size() == 0) begin
                        chk("pop_unexpected", out_valid, 0);
                    end else begin
                        chk("out_pc", out_pc, exp_pc[0]);
                        chk("out_inst", out_inst, exp_inst[0]);
                        void'(exp_pc.pop_front());
                        void'(exp_inst.pop_front());
                        void'(exp_filled.pop_front());
                        pop_cnt++;
                        if (arm_pop) begin
                            first_pop_pc = out_pc;
                            arm_pop = 0;
                        end
                    end
                end
                if (req_valid && req_ready) begin
                    int d;
                    chk("req_addr", req_addr, model_pc);
                    exp_pc.push_back(model_pc);
                    exp_inst.push_back(model_pc[31:0]);
                    exp_filled.push_back(0);
                    d = cyc + 1 + int'($urandom_range(lat_max, lat_min));
                    if (d <= last_due) d = last_due + 1;
                    last_due = d;
                    mem_addr.push_back(model_pc);
                    mem_due.push_back(d);
                    mem_stale.push_back(0);
                    if (arm_req) begin
                        first_req_addr = req_addr;
                        arm_req = 0;
                    end
                    last_req_addr = req_addr;
                    req_cnt++;
                    model_pc = model_pc + 64'd4;
                end
            end
            since_rst++;
        end
    end

    // One cycle of stimulus: drive just after the rising edge, return after the monitor has run.
    task automatic step();
        @(posedge clk);
        #1;
        req_ready  = ($urandom_range(99) < rr_pct);
        out_ready  = ($urandom_range(99) < or_pct);
        resp_valid = 1'b0;
        resp_data  = '0;
        if (mem_due.size() > 0 && mem_due[0] <= cyc) begin
            resp_valid = 1'b1;
            resp_data  = mem_addr[0][31:0];
        end
        redirect_valid = 1'b0;
        if (redir_pct > 0 && $urandom_range(99) < redir_pct) begin
            redirect_valid = 1'b1;
            redirect_pc    = {32'h0, $urandom()};
        end
        if (force_redir || (redir_on_ov && out_valid && resp_valid)) begin
            redirect_valid = 1'b1;
            redirect_pc    = redir_target;
            force_redir    = 0;
            redir_on_ov    = 0;
        end
        @(negedge clk);
        #1;
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic reset_dut();
        rst = 1'b0;
        #1;
        chk("rst_req_valid", req_valid, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_pc", out_pc, 0);
        chk("rst_out_inst", out_inst, 0);
        req_ready = 0; out_ready = 0; resp_valid = 0; redirect_valid = 0;
        exp_pc.delete(); exp_inst.delete(); exp_filled.delete();
        mem_addr.delete(); mem_due.delete(); mem_stale.delete();
        model_pc = RESET_PC;
        last_due = 0;
        req_cnt  = 0;
        arm_req  = 1;
        arm_pop  = 1;
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
    endtask

    task automatic drain();
        rr_pct = 0;
        or_pct = 100;
        for (int i = 0; i < 100 && (exp_pc.size() != 0 || mem_addr.size() != 0); i++) step();
        chk("drain_empty", exp_pc.size() + mem_addr.size(), 0);
    endtask

    initial begin
        int p0;
        #2 reset_dut();

        // Streaming with single-cycle memory: one instruction per cycle once running.
        rr_pct = 100; or_pct = 100; lat_min = 0; lat_max = 0;
        run_cycles(20);
        p0 = pop_cnt;
        run_cycles(20);
        chk("stream_rate", pop_cnt - p0, 20);
        chk("stream_first_req", first_req_addr, RESET_PC);
        drain();

        // IDU stalled: queue fills to DEPTH, then drains in order.
        reset_dut();
        rr_pct = 100; or_pct = 0;
        run_cycles(12);
        chk("full_req_cnt", req_cnt, 4);
        chk("full_req_valid", req_valid, 0);
        chk("full_out_valid", out_valid, 1);
        chk("full_out_pc", out_pc, 64'h8000_0000);
        or_pct = 100;
        for (int i = 0; i < 30 && req_cnt < 5; i++) step();
        chk("resume_addr", last_req_addr, 64'h8000_0010);
        drain();

        // Redirect with two requests in flight at latency 3.
        reset_dut();
        or_pct = 100; lat_min = 3; lat_max = 3;
        for (int i = 0; i < 20 && req_cnt < 2; i++) begin
            rr_pct = 100;
            step();
        end
        rr_pct = 0;
        redir_target = 64'h8000_0102;
        force_redir  = 1;
        step();
        rr_pct = 100;
        run_cycles(15);
        chk("redir_first_req", first_req_addr, 64'h8000_0100);
        chk("redir_first_pop", first_pop_pc, 64'h8000_0100);
        drain();

        // Redirect coinciding with a response and an output handshake, three unfilled entries.
        reset_dut();
        or_pct = 100; lat_min = 4; lat_max = 4;
        redir_target = 64'h9000_0043;
        redir_seen   = 0;
        redir_on_ov  = 1;
        for (int i = 0; i < 30 && !redir_seen; i++) begin
            rr_pct = (req_cnt < 4) ? 100 : 0;
            step();
        end
        chk("kill_redir_seen", redir_seen, 1);
        redir_on_ov = 0;
        rr_pct = 0;
        step();
        chk("kill_empty", out_valid, 0);
        run_cycles(6);
        for (int i = 0; i < 20 && req_cnt < 5; i++) begin
            rr_pct = 100;
            step();
        end
        rr_pct = 0;
        run_cycles(10);
        chk("kill_first_pop", first_pop_pc, 64'h9000_0040);
        drain();

        // Random backpressure, latency 0-5 and occasional redirects over 200 instructions.
        reset_dut();
        rr_pct = 50; or_pct = 60; lat_min = 0; lat_max = 5; redir_pct = 2;
        p0 = pop_cnt;
        for (int i = 0; i < 4000 && (pop_cnt - p0) < 200; i++) step();
        chk("random_progress", (pop_cnt - p0) >= 200, 1);
        redir_pct = 0;
        drain();

        // Asynchronous reset in the middle of a stream.
        rr_pct = 100; or_pct = 100; lat_min = 0; lat_max = 2;
        run_cycles(30);
        reset_dut();
        rr_pct = 100; or_pct = 100;
        run_cycles(8);
        chk("post_rst_first_req", first_req_addr, RESET_PC);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end
endmodule
